// File: rtl/action_pkg.sv
// ============================================================================
// Module      : action_pkg
// Description : Shared widths, opcodes and table-entry type for the
//               match-action issue path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package action_pkg;

    localparam int ACTION_LEN = 25;
    localparam int PHV_LEN    = 1579;
    localparam int KEY_W_DEF  = 16;
    localparam int IDX_W_DEF  = 4;
    localparam int TAG_W_DEF  = KEY_W_DEF - IDX_W_DEF;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_ADD     = 4'b0001;
    localparam logic [3:0] OP_ADDI    = 4'b0011;
    localparam logic [3:0] OP_LOAD    = 4'b0101;
    localparam logic [3:0] OP_STORE   = 4'b0110;
    localparam logic [3:0] OP_REDIR   = 4'b1000;
    localparam logic [3:0] OP_DISCARD = 4'b1001;

    typedef struct packed {
        logic                  vld;
        logic [TAG_W_DEF-1:0]  tag;
        logic [ACTION_LEN-1:0] action;
    } entry_t;

    function automatic logic [3:0] opcode_of(input logic [ACTION_LEN-1:0] act);
        return act[ACTION_LEN-1 -: 4];
    endfunction

endpackage

`default_nettype wire

// File: rtl/action_table_ram.sv
// ============================================================================
// Module      : action_table_ram
// Description : Direct-mapped action table, one write port and one registered
//               read-first read port; valid bits live in resettable flops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module action_table_ram #(
    parameter int IDX_W = 4,
    parameter int TAG_W = 12,
    parameter int ACT_W = 25
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_addr_i,
    input  logic             wr_vld_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [ACT_W-1:0] wr_action_i,
    input  logic [IDX_W-1:0] rd_addr_i,
    output logic             rd_vld_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [ACT_W-1:0] rd_action_o
);
    import action_pkg::*;

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] vld_q;
    logic [TAG_W-1:0] tag_mem_q    [DEPTH];
    logic [ACT_W-1:0] action_mem_q [DEPTH];
    logic             rd_vld_q;
    logic [TAG_W-1:0] rd_tag_q;
    logic [ACT_W-1:0] rd_action_q;

    // Reads sample the array before this edge's write lands (read-first).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q    <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                vld_q[wr_addr_i] <= wr_vld_i;
            end
            rd_vld_q <= vld_q[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_mem_q[wr_addr_i]    <= wr_tag_i;
            action_mem_q[wr_addr_i] <= wr_action_i;
        end
        rd_tag_q    <= tag_mem_q[rd_addr_i];
        rd_action_q <= action_mem_q[rd_addr_i];
    end

    assign rd_vld_o    = rd_vld_q;
    assign rd_tag_o    = rd_tag_q;
    assign rd_action_o = rd_action_q;

endmodule

`default_nettype wire

// File: rtl/action_issuer.sv
// ============================================================================
// Module      : action_issuer
// Description : Key extraction, two-stage table lookup and hit/miss counters
//               feeding action_engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module action_issuer #(
    parameter int STAGE      = 0,
    parameter int PHV_LEN    = action_pkg::PHV_LEN,
    parameter int ACTION_LEN = action_pkg::ACTION_LEN,
    parameter int KEY_LSB    = 0,
    parameter int KEY_W      = 16,
    parameter int IDX_W      = 4
) (
    input  logic                    axis_clk,
    input  logic                    areset,
    input  logic [PHV_LEN-1:0]      phv_in,
    input  logic                    phv_in_valid,
    input  logic                    cfg_wr_en,
    input  logic [IDX_W-1:0]        cfg_wr_addr,
    input  logic                    cfg_wr_vld,
    input  logic [KEY_W-IDX_W-1:0]  cfg_wr_tag,
    input  logic [ACTION_LEN-1:0]   cfg_wr_action,
    output logic [ACTION_LEN-1:0]   action_out,
    output logic                    action_out_valid,
    output logic [PHV_LEN-1:0]      phv_out,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);
    import action_pkg::*;

    localparam int TAG_W = KEY_W - IDX_W;

    logic [KEY_W-1:0]      w_key;
    logic                  w_wr_en;
    logic                  w_rd_vld;
    logic [TAG_W-1:0]      w_rd_tag;
    logic [ACTION_LEN-1:0] w_rd_action;
    logic                  w_hit;

    logic                  s1_valid_q;
    logic [TAG_W-1:0]      s1_tag_q;
    logic [PHV_LEN-1:0]    s1_phv_q;

    logic [ACTION_LEN-1:0] action_out_q,  action_out_d;
    logic                  out_valid_q;
    logic [PHV_LEN-1:0]    phv_out_q,     phv_out_d;
    logic [31:0]           hit_cnt_q,     hit_cnt_d;
    logic [31:0]           miss_cnt_q,    miss_cnt_d;

    assign w_key   = phv_in[KEY_LSB +: KEY_W];
    assign w_wr_en = cfg_wr_en & ~areset;

    // The table's registered read port doubles as the S1 action/tag register.
    action_table_ram #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W),
        .ACT_W (ACTION_LEN)
    ) u_table (
        .clk_i       (axis_clk),
        .rst_i       (areset),
        .wr_en_i     (w_wr_en),
        .wr_addr_i   (cfg_wr_addr),
        .wr_vld_i    (cfg_wr_vld),
        .wr_tag_i    (cfg_wr_tag),
        .wr_action_i (cfg_wr_action),
        .rd_addr_i   (w_key[IDX_W-1:0]),
        .rd_vld_o    (w_rd_vld),
        .rd_tag_o    (w_rd_tag),
        .rd_action_o (w_rd_action)
    );

    always_ff @(posedge axis_clk) begin
        s1_tag_q <= w_key[KEY_W-1:IDX_W];
        s1_phv_q <= phv_in;
    end

    assign w_hit = w_rd_vld && (w_rd_tag == s1_tag_q);

    always_comb begin
        action_out_d = '0;
        phv_out_d    = '0;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (s1_valid_q) begin
            phv_out_d = s1_phv_q;
            if (w_hit) begin
                action_out_d = w_rd_action;
                if (hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
            end else if (miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (areset) begin
            s1_valid_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            action_out_q <= '0;
            phv_out_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            s1_valid_q   <= phv_in_valid;
            out_valid_q  <= s1_valid_q;
            action_out_q <= action_out_d;
            phv_out_q    <= phv_out_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign action_out       = action_out_q;
    assign action_out_valid = out_valid_q;
    assign phv_out          = phv_out_q;
    assign hit_cnt          = hit_cnt_q;
    assign miss_cnt         = miss_cnt_q;

endmodule

`default_nettype wire
